// File: rtl/fft_params_pkg.sv
// Shared parameters and types for the 256-point FFT pipeline.
// Includes the output sample type and the bit-reversal helper used by the reorder stage.
package fft_params_pkg;

  localparam int N            = 256;
  localparam int STAGES       = 8;
  localparam int OUTPUT_WIDTH = 18;
  localparam int OUTPUT_FRAC  = 14;

  typedef struct packed {
    logic signed [OUTPUT_WIDTH-1:0] re;
    logic signed [OUTPUT_WIDTH-1:0] im;
  } cplx_out_t;

  function automatic logic [STAGES-1:0] bit_reverse(input logic [STAGES-1:0] idx);
    logic [STAGES-1:0] rev;
    for (int i = 0; i < STAGES; i++) begin
      rev[i] = idx[STAGES-1-i];
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft256_reorder_bank.sv
// One bank of the reorder buffer: N complex samples, one synchronous write port
// and one asynchronous read port. Contents are never reset.
module fft256_reorder_bank
  import fft_params_pkg::*;
#(
  parameter int N      = fft_params_pkg::N,
  parameter int STAGES = fft_params_pkg::STAGES
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [STAGES-1:0] wr_addr,
  input  cplx_out_t         wr_data,
  input  logic [STAGES-1:0] rd_addr,
  output cplx_out_t         rd_data
);

  cplx_out_t mem [N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft256_output_reorder.sv
// Ping-pong reorder buffer: writes each frame in bit-reversed order into one bank
// while the other bank is streamed out in natural order on a valid/ready interface.
module fft256_output_reorder
  import fft_params_pkg::*;
#(
  parameter int N            = fft_params_pkg::N,
  parameter int STAGES       = fft_params_pkg::STAGES,
  parameter int OUTPUT_WIDTH = fft_params_pkg::OUTPUT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [OUTPUT_WIDTH-1:0] in_re,
  input  logic signed [OUTPUT_WIDTH-1:0] in_im,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [OUTPUT_WIDTH-1:0] out_re,
  output logic signed [OUTPUT_WIDTH-1:0] out_im,
  output logic                           out_last,
  output logic                           frame_err
);

  localparam logic [STAGES-1:0] LAST_IDX = STAGES'(N - 1);

  logic [STAGES-1:0] wr_idx_q, wr_idx_d;
  logic [STAGES-1:0] rd_idx_q, rd_idx_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              frame_err_q, frame_err_d;
  cplx_out_t         out_data_q, out_data_d;

  logic              wr_fire, wr_wrap, rd_load, rd_wrap;
  logic [1:0]        bank_we;
  logic [STAGES-1:0] wr_addr;
  cplx_out_t         wr_data, rd_data;
  cplx_out_t         bank_rd_data [2];

  assign in_ready = !full_q[wr_bank_q];
  assign wr_fire  = in_valid && in_ready;
  assign wr_wrap  = (wr_idx_q == LAST_IDX);
  assign rd_wrap  = (rd_idx_q == LAST_IDX);
  // The output register may refill whenever it is empty or being consumed this cycle.
  assign rd_load  = full_q[rd_bank_q] && (!out_valid_q || out_ready);

  assign wr_addr    = bit_reverse(wr_idx_q);
  assign wr_data.re = in_re;
  assign wr_data.im = in_im;
  assign bank_we    = {wr_fire && wr_bank_q, wr_fire && !wr_bank_q};
  assign rd_data    = bank_rd_data[rd_bank_q];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft256_reorder_bank #(
      .N      (N),
      .STAGES (STAGES)
    ) u_bank (
      .clk     (clk),
      .wr_en   (bank_we[b]),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_idx_q),
      .rd_data (bank_rd_data[b])
    );
  end

  always_comb begin
    wr_idx_d    = wr_idx_q;
    wr_bank_d   = wr_bank_q;
    rd_idx_d    = rd_idx_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    frame_err_d = 1'b0;

    // The write counter alone decides frame boundaries; in_last is only cross-checked.
    if (wr_fire) begin
      wr_idx_d    = wr_idx_q + 1'b1;
      frame_err_d = (in_last != wr_wrap);
      if (wr_wrap) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end

    // Set and clear of full always hit different banks, so both can apply together.
    if (rd_load) begin
      out_valid_d = 1'b1;
      out_data_d  = rd_data;
      out_last_d  = rd_wrap;
      rd_idx_d    = rd_idx_q + 1'b1;
      if (rd_wrap) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      wr_bank_q   <= wr_bank_d;
      rd_idx_q    <= rd_idx_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_re    = out_data_q.re;
  assign out_im    = out_data_q.im;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fft256_output_reorder.sv
// Self-checking bench for fft256_output_reorder: a bit-reversal model fills a
// scoreboard per completed input frame and a negedge monitor pops and compares outputs.
module tb_fft256_output_reorder;

  localparam int W  = 18;
  localparam int NP = 256;

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_last;
  logic         out_valid, out_ready, out_last, frame_err;
  logic [W-1:0] in_re, in_im, out_re, out_im;

  int   checks = 0;
  int   errors = 0;

  exp_t         sb[$];
  exp_t         mon_e, mon_p;
  logic [W-1:0] m_re [NP];
  logic [W-1:0] m_im [NP];
  int           m_idx = 0;
  int           acc_count = 0, pop_count = 0, ready_low = 0, err_seen = 0, cyc = 0;
  int           phase_base = 0, phase_first = 0, phase_last = 0;
  logic         err_pend = 1'b0, stall_prev = 1'b0;
  logic [W-1:0] prev_re, prev_im;

  always #5 clk = ~clk;

  fft256_output_reorder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last),
    .frame_err (frame_err)
  );

  function automatic int tb_bitrev(input int k);
    int r = 0;
    for (int i = 0; i < 8; i++) begin
      if ((k & (1 << i)) != 0) r = r | (1 << (7 - i));
    end
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: checks outputs against the scoreboard and models accepted inputs.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      check_output("frame_err", 64'(frame_err), 64'(err_pend));
      if (frame_err) err_seen++;
      if (stall_prev) begin
        check_output("stall_valid", 64'(out_valid), 64'd1);
        check_output("stall_re", 64'(out_re), 64'(prev_re));
        check_output("stall_im", 64'(out_im), 64'(prev_im));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_output("unexpected_out", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check_output("out_re", 64'(out_re), 64'(mon_e.re));
          check_output("out_im", 64'(out_im), 64'(mon_e.im));
          check_output("out_last", 64'(out_last), 64'(mon_e.last));
        end
        if (pop_count == phase_base) phase_first = cyc;
        phase_last = cyc;
        pop_count++;
      end
      stall_prev = out_valid && !out_ready;
      prev_re    = out_re;
      prev_im    = out_im;
      err_pend   = 1'b0;
      if (!in_ready) ready_low++;
      if (in_valid && in_ready) begin
        err_pend = (in_last != (m_idx == NP - 1));
        m_re[tb_bitrev(m_idx)] = in_re;
        m_im[tb_bitrev(m_idx)] = in_im;
        acc_count++;
        if (m_idx == NP - 1) begin
          for (int b = 0; b < NP; b++) begin
            mon_p.re   = m_re[b];
            mon_p.im   = m_im[b];
            mon_p.last = (b == NP - 1);
            sb.push_back(mon_p);
          end
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] re, input logic [W-1:0] im, input logic last);
    in_valid = v;
    in_re    = re;
    in_im    = im;
    in_last  = last;
    @(posedge clk);
    #1;
  endtask

  // Streams n accepted samples of random data; rand_mode also randomises out_ready.
  task automatic apply_stimulus(input int n, input bit rand_mode, input int last_at);
    int target = acc_count + n;
    int budget = 0;
    while (acc_count < target && budget < 40000) begin
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
      drive(rand_mode ? 1'($urandom_range(0, 1)) : 1'b1, W'($urandom), W'($urandom),
            (m_idx == last_at));
      budget++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (acc_count < target) check_output("stream_timeout", 64'(acc_count), 64'(target));
  endtask

  task automatic wait_idle();
    int i = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && i < 4000) begin
      @(posedge clk);
      #1;
      i++;
    end
    check_output("drain_done", 64'(sb.size() == 0 && !out_valid), 64'd1);
  endtask

  initial begin
    int base;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_out_last", 64'(out_last), 64'd0);
    check_output("rst_out_re", 64'(out_re), 64'd0);
    check_output("rst_out_im", 64'(out_im), 64'd0);
    check_output("rst_frame_err", 64'(frame_err), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_output("rst_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] single frame");
    base = pop_count;
    for (int k = 0; k < NP; k++) begin
      drive(1'b1, W'(tb_bitrev(k)), W'(-tb_bitrev(k)), (k == NP - 1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_output("latency_not_early", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check_output("latency_bin0_valid", 64'(out_valid), 64'd1);
    check_output("bin0_re", 64'(out_re), 64'd0);
    check_output("bin0_last", 64'(out_last), 64'd0);
    wait_idle();
    check_output("single_pops", 64'(pop_count - base), 64'd256);

    $display("[TB] back-to-back");
    phase_base = pop_count;
    ready_low  = 0;
    apply_stimulus(4 * NP, 1'b0, NP - 1);
    check_output("b2b_ready_low", 64'(ready_low), 64'd0);
    wait_idle();
    check_output("b2b_pops", 64'(pop_count - phase_base), 64'd1024);
    check_output("b2b_contiguous", 64'(phase_last - phase_first), 64'd1023);

    $display("[TB] backpressure");
    base      = acc_count;
    out_ready = 1'b0;
    for (int c = 0; c < 600; c++) begin
      drive(1'b1, W'($urandom), W'($urandom), (m_idx == NP - 1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_output("bp_accepted", 64'(acc_count - base), 64'd512);
    check_output("bp_in_ready", 64'(in_ready), 64'd0);
    base = pop_count;
    wait_idle();
    check_output("bp_pops", 64'(pop_count - base), 64'd512);

    $display("[TB] random stalls");
    base = pop_count;
    apply_stimulus(10 * NP, 1'b1, NP - 1);
    wait_idle();
    check_output("rand_pops", 64'(pop_count - base), 64'd2560);

    $display("[TB] framing error");
    base = err_seen;
    apply_stimulus(NP, 1'b0, 100);
    wait_idle();
    check_output("frame_err_count", 64'(err_seen - base), 64'd2);

    $display("[TB] reset mid-frame");
    apply_stimulus(NP + 130, 1'b0, NP - 1);
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    sb.delete();
    m_idx      = 0;
    err_pend   = 1'b0;
    stall_prev = 1'b0;
    #1;
    check_output("midrst_out_valid", 64'(out_valid), 64'd0);
    check_output("midrst_out_last", 64'(out_last), 64'd0);
    check_output("midrst_out_re", 64'(out_re), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_output("midrst_in_ready", 64'(in_ready), 64'd1);
    base = pop_count;
    apply_stimulus(NP, 1'b0, NP - 1);
    wait_idle();
    check_output("midrst_pops", 64'(pop_count - base), 64'd256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
